// File: rtl/debounce_pulse_gen_pkg.sv
// Shared definitions for debounce_pulse_gen: debounce FSM state encoding and a
// small elaboration-time helper.
package debounce_pulse_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_PRESS = 2'd1,
    ST_PRESSED    = 2'd2,
    ST_WAIT_REL   = 2'd3
  } state_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/debounce_pulse_gen_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input; reusable for every
// asynchronous input in the design. Both stages clear to 0 on rst.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic r_s0;
  logic r_s1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s0 <= 1'b0;
      r_s1 <= 1'b0;
    end else begin
      r_s0 <= d;
      r_s1 <= r_s0;
    end
  end

  assign q = r_s1;

endmodule

// File: rtl/debounce_pulse_gen.sv
// Push-button synchroniser + stable-time debouncer producing a debounced level and
// a one-cycle enable pulse per press. Auto-repeat is built when DEBOUNCE_REPEAT_EN is defined.
module debounce_pulse_gen #(
  parameter int unsigned N_ESTABLE  = 250000,
  parameter int unsigned REP_DELAY  = 12500000,
  parameter int unsigned REP_PERIOD = 2500000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic btn_level,
  output logic ena_out
);

  import debounce_pulse_gen_pkg::*;

  localparam int unsigned CNT_W = $clog2(N_ESTABLE + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_ESTABLE - 1);

  // A filter shorter than 2 or a repeat spacing below 2 would break the
  // one-cycle-wide, never-back-to-back pulse guarantee.
  if (N_ESTABLE < 2 || REP_DELAY < 2 || REP_PERIOD < 2) begin : g_param_check
    $error("debounce_pulse_gen: N_ESTABLE, REP_DELAY and REP_PERIOD must be >= 2");
  end

  logic             w_s1;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_level;
  logic             r_ena;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn_in),
    .q   (w_s1)
  );

`ifdef DEBOUNCE_REPEAT_EN
  localparam int unsigned REP_W = $clog2(max_u(REP_DELAY, REP_PERIOD) + 1);

  logic [REP_W-1:0] r_rep_cnt;
  logic             r_rep_first;
  logic [REP_W-1:0] w_rep_last;

  assign w_rep_last = r_rep_first ? REP_W'(REP_DELAY - 1) : REP_W'(REP_PERIOD - 1);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_ena   <= 1'b0;
`ifdef DEBOUNCE_REPEAT_EN
      r_rep_cnt   <= '0;
      r_rep_first <= 1'b1;
`endif
    end else begin
      r_ena <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_s1) begin
            r_state <= ST_WAIT_PRESS;
            r_cnt   <= CNT_W'(1);
          end
        end
        ST_WAIT_PRESS: begin
          if (!w_s1) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end else if (r_cnt == CNT_LAST) begin
            r_state <= ST_PRESSED;
            r_level <= 1'b1;
            r_ena   <= 1'b1;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_PRESSED: begin
          if (!w_s1) begin
            r_state <= ST_WAIT_REL;
            r_cnt   <= CNT_W'(1);
          end
        end
        ST_WAIT_REL: begin
          // A return to 1 before the filter expires is a release glitch: no pulse.
          if (w_s1) begin
            r_state <= ST_PRESSED;
            r_cnt   <= '0;
          end else if (r_cnt == CNT_LAST) begin
            r_state <= ST_IDLE;
            r_level <= 1'b0;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
        end
      endcase
`ifdef DEBOUNCE_REPEAT_EN
      // Repeat timer runs while held, freezes across a release glitch, clears otherwise.
      if (r_state == ST_PRESSED) begin
        if (r_rep_cnt == w_rep_last) begin
          r_ena       <= 1'b1;
          r_rep_cnt   <= '0;
          r_rep_first <= 1'b0;
        end else begin
          r_rep_cnt <= r_rep_cnt + REP_W'(1);
        end
      end else if (r_state != ST_WAIT_REL) begin
        r_rep_cnt   <= '0;
        r_rep_first <= 1'b1;
      end
`endif
    end
  end

  assign btn_level = r_level;
  assign ena_out   = r_ena;

endmodule

// File: tb/tb_debounce_pulse_gen.sv
// Self-checking bench for debounce_pulse_gen: directed scenarios with fixed timing
// expectations plus randomized bounce traffic against a sliding-window reference model.
module tb_debounce_pulse_gen;

  localparam int N = 4;
  localparam int D = 10;
  localparam int P = 5;
  localparam logic [63:0] MASK = (64'd1 << N) - 64'd1;

  logic clk;
  logic rst;
  logic btn_in;
  logic btn_level;
  logic ena_out;

  int n_tests = 0;
  int n_fail  = 0;

  debounce_pulse_gen #(
    .N_ESTABLE  (N),
    .REP_DELAY  (D),
    .REP_PERIOD (P)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .btn_in    (btn_in),
    .btn_level (btn_level),
    .ena_out   (ena_out)
  );

  always #5 clk = ~clk;

  // Reference model: the level flips once the last N synchronised samples all
  // disagree with it; a pulse accompanies every rising flip.
  logic        m_s0      = 1'b0;
  logic        m_s1      = 1'b0;
  logic        m_prev_s1 = 1'b0;
  logic        m_level   = 1'b0;
  logic        m_ena     = 1'b0;
  logic [63:0] m_hist    = '0;
  logic [63:0] m_win;
  logic        m_rise;
  logic        m_fall;
  logic        m_rep_fire;

  assign m_win  = {m_hist[62:0], m_s1} & MASK;
  assign m_rise = !m_level && (m_win == MASK);
  assign m_fall = m_level && (m_win == 64'd0);

`ifdef DEBOUNCE_REPEAT_EN
  int m_rep = 0;  // cycles spent held (excluding release-glitch cycles) since the press
  assign m_rep_fire = m_level && m_prev_s1 &&
                      (((m_rep + 1) == D) || (((m_rep + 1) > D) && (((m_rep + 1 - D) % P) == 0)));
  always @(posedge clk) begin
    if (rst || !m_level || m_rise) m_rep <= 0;
    else if (m_prev_s1)            m_rep <= m_rep + 1;
  end
`else
  assign m_rep_fire = 1'b0;
`endif

  always @(posedge clk) begin
    if (rst) begin
      m_s0      <= 1'b0;
      m_s1      <= 1'b0;
      m_prev_s1 <= 1'b0;
      m_level   <= 1'b0;
      m_ena     <= 1'b0;
      m_hist    <= '0;
    end else begin
      m_s0      <= btn_in;
      m_s1      <= m_s0;
      m_prev_s1 <= m_s1;
      m_hist    <= {m_hist[62:0], m_s1};
      m_level   <= m_rise ? 1'b1 : (m_fall ? 1'b0 : m_level);
      m_ena     <= m_rise || m_rep_fire;
    end
  end

  task automatic settle();
    btn_in = 1'b0;
    rst    = 1'b0;
    repeat (N + 10) @(negedge clk);
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    btn_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_tests++;
      if (btn_level !== 1'b0 || ena_out !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_hold cyc=%0d level=%b ena=%b exp=0/0", i, btn_level, ena_out);
      end
    end
    rst = 1'b0;
    for (int j = 1; j <= 12; j++) begin
      @(negedge clk);
      n_tests++;
      if (ena_out !== (j == 6) || btn_level !== (j >= 6)) begin
        n_fail++;
        $display("FAIL reset_release cyc=%0d level=%b ena=%b exp=%b/%b",
                 j, btn_level, ena_out, (j >= 6), (j == 6));
      end
    end
  endtask

  task automatic test_clean_press();
    logic exp_ena;
    btn_in = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      exp_ena = (i == 6);
`ifdef DEBOUNCE_REPEAT_EN
      exp_ena = exp_ena || (i == 16) || (i == 21);
`endif
      n_tests++;
      if (ena_out !== exp_ena || btn_level !== (i >= 6 && i < 26)) begin
        n_fail++;
        $display("FAIL clean_press cyc=%0d level=%b ena=%b exp=%b/%b",
                 i, btn_level, ena_out, (i >= 6 && i < 26), exp_ena);
      end
      n_tests++;
      if (ena_out !== m_ena || btn_level !== m_level) begin
        n_fail++;
        $display("FAIL clean_press_model cyc=%0d level=%b ena=%b exp=%b/%b",
                 i, btn_level, ena_out, m_level, m_ena);
      end
      if (i == 20) btn_in = 1'b0;
    end
  endtask

  task automatic test_press_bounce();
    logic pat [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    btn_in = pat[0];
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      n_tests++;
      if (btn_level !== 1'b0 || ena_out !== 1'b0) begin
        n_fail++;
        $display("FAIL press_bounce cyc=%0d level=%b ena=%b exp=0/0", i, btn_level, ena_out);
      end
      btn_in = (i < 7) ? pat[i] : 1'b0;
    end
  endtask

  task automatic test_release_glitch();
    btn_in = 1'b1;
    for (int i = 1; i <= 24; i++) begin
      @(negedge clk);
      n_tests++;
      if (ena_out !== (i == 6) || btn_level !== (i >= 6 && i < 21)) begin
        n_fail++;
        $display("FAIL release_glitch cyc=%0d level=%b ena=%b exp=%b/%b",
                 i, btn_level, ena_out, (i >= 6 && i < 21), (i == 6));
      end
      if (i == 10) btn_in = 1'b0;
      if (i == 13) btn_in = 1'b1;
      if (i == 15) btn_in = 1'b0;
    end
  endtask

  task automatic test_reset_mid_filter();
    int pulses = 0;
    btn_in = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      pulses += int'(ena_out);
      n_tests++;
      if (ena_out !== (i == 11) || btn_level !== (i >= 11)) begin
        n_fail++;
        $display("FAIL reset_mid_filter cyc=%0d level=%b ena=%b exp=%b/%b",
                 i, btn_level, ena_out, (i >= 11), (i == 11));
      end
      if (i == 4) rst = 1'b1;
      if (i == 5) rst = 1'b0;
    end
    n_tests++;
    if (pulses != 1) begin
      n_fail++;
      $display("FAIL reset_mid_filter_count pulses=%0d exp=1", pulses);
    end
  endtask

`ifdef DEBOUNCE_REPEAT_EN
  task automatic test_repeat();
    int  pulses = 0;
    logic exp_ena;
    btn_in = 1'b1;
    for (int i = 1; i <= 45; i++) begin
      @(negedge clk);
      exp_ena = (i inside {6, 16, 21, 26, 31});
      pulses += int'(ena_out);
      n_tests++;
      if (ena_out !== exp_ena || btn_level !== (i >= 6 && i < 36)) begin
        n_fail++;
        $display("FAIL repeat cyc=%0d level=%b ena=%b exp=%b/%b",
                 i, btn_level, ena_out, (i >= 6 && i < 36), exp_ena);
      end
      if (i == 30) btn_in = 1'b0;
    end
    n_tests++;
    if (pulses != 5) begin
      n_fail++;
      $display("FAIL repeat_count pulses=%0d exp=5", pulses);
    end
  endtask
`endif

  task automatic test_random();
    logic prev_ena = 1'b0;
    int   dut_p    = 0;
    int   mod_p    = 0;
    int   left     = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      n_tests++;
      if (btn_level !== m_level || ena_out !== m_ena) begin
        n_fail++;
        $display("FAIL random_model cyc=%0d level=%b ena=%b exp=%b/%b",
                 i, btn_level, ena_out, m_level, m_ena);
      end
      n_tests++;
      if (ena_out === 1'b1 && prev_ena === 1'b1) begin
        n_fail++;
        $display("FAIL random_back_to_back cyc=%0d ena=%b prev=%b exp=not both 1", i, ena_out, prev_ena);
      end
      prev_ena = ena_out;
      dut_p += int'(ena_out);
      mod_p += int'(m_ena);
      if (left == 0) begin
        btn_in = 1'($urandom_range(0, 1));
        left   = int'($urandom_range(1, 2 * N + 2));
      end else begin
        left--;
      end
      rst = ($urandom_range(0, 59) == 0);
    end
    n_tests++;
    if (dut_p != mod_p) begin
      n_fail++;
      $display("FAIL random_pulse_count dut=%0d exp=%0d", dut_p, mod_p);
    end
  endtask

  initial begin
    clk    = 1'b0;
    rst    = 1'b1;
    btn_in = 1'b0;
    test_reset();
    settle();
    test_clean_press();
    settle();
    test_press_bounce();
    settle();
    test_release_glitch();
    settle();
    test_reset_mid_filter();
    settle();
`ifdef DEBOUNCE_REPEAT_EN
    test_repeat();
    settle();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
